// File: rtl/pc_kontrolli.sv
// Program-counter controller: sequences fetch, execute-wait and PC update for a
// 24-bit word-addressed core, with relative branch, absolute jump and halt.
module pc_kontrolli #(
    parameter logic [23:0] RESET_VECTOR = 24'h000000,
    parameter logic [23:0] INCREMENT    = 24'h000001
) (
    input  logic        Clock,
    input  logic        Reset_n,
    output logic [23:0] pc,
    output logic        fetch_req,
    output logic [23:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [23:0] fetch_data,
    output logic [23:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [23:0] branch_offset,
    input  logic        jump,
    input  logic [23:0] jump_target,
    input  logic        halt,
    input  logic        stall,
    output logic        halted,
    output logic        pc_wrap
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitExec,
        StUpdate,
        StHalt
    } state_e;

    state_e      state_q;
    logic [23:0] pc_q;
    logic [23:0] instr_q;
    logic        fetch_req_q;
    logic        instr_valid_q;
    logic        halted_q;
    logic        pc_wrap_q;

    // Sums carried in 26 bits so the exact signed result is representable;
    // any non-zero value in bits [25:24] means the result left 0..2^24-1.
    logic [25:0] seq_sum;
    logic [25:0] br_sum;
    logic [23:0] pc_next;
    logic        wrap_next;

    always_comb begin
        seq_sum   = {2'b00, pc_q} + {2'b00, INCREMENT};
        br_sum    = seq_sum + {{2{branch_offset[23]}}, branch_offset};
        pc_next   = seq_sum[23:0];
        wrap_next = (seq_sum[25:24] != 2'b00);
        if (!halt && jump) begin
            pc_next   = jump_target;
            wrap_next = 1'b0;
        end else if (!halt && branch_taken) begin
            pc_next   = br_sum[23:0];
            wrap_next = (br_sum[25:24] != 2'b00);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_VECTOR;
            instr_q       <= 24'h000000;
            fetch_req_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            pc_wrap_q     <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;
            pc_wrap_q     <= 1'b0;
            case (state_q)
                StIdle, StUpdate: begin
                    if (!stall) begin
                        state_q     <= StFetch;
                        fetch_req_q <= 1'b1;
                    end
                end
                StFetch: begin
                    if (fetch_ack) begin
                        state_q       <= StWaitExec;
                        fetch_req_q   <= 1'b0;
                        instr_q       <= fetch_data;
                        instr_valid_q <= 1'b1;
                    end
                end
                StWaitExec: begin
                    if (exec_done) begin
                        pc_q      <= pc_next;
                        pc_wrap_q <= wrap_next;
                        if (halt) begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= StUpdate;
                        end
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q     <= StIdle;
                    fetch_req_q <= 1'b0;
                end
            endcase
        end
    end

    // pc only moves on the execute edge, so it is stable for a whole fetch.
    assign fetch_addr  = pc_q;
    assign pc          = pc_q;
    assign fetch_req   = fetch_req_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign pc_wrap     = pc_wrap_q;

endmodule

// File: doc/pc_kontrolli.md
PC_KONTROLLI -- requirements
Module: pc_kontrolli

Interface
REQ-001 Parameter: RESET_VECTOR, default 24'h000000, PC value loaded at reset.
REQ-002 Parameter: INCREMENT, default 24'h000001, sequential step in words.
REQ-003 Port: Clock  in  1  single clock; all state changes on rising edge.
REQ-004 Port: Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: pc  out  24  current program counter.
REQ-006 Port: fetch_req  out  1  instruction-fetch request to memory.
REQ-007 Port: fetch_addr  out  24  fetch address, equal to pc while fetch_req=1.
REQ-008 Port: fetch_ack  in  1  memory accepts request; fetch_data valid the same cycle.
REQ-009 Port: fetch_data  in  24  instruction word from memory.
REQ-010 Port: instr  out  24  latched instruction for decode.
REQ-011 Port: instr_valid  out  1  one-cycle pulse when instr is newly loaded.
REQ-012 Port: exec_done  in  1  execute stage finished the current instruction.
REQ-013 Port: branch_taken  in  1  relative branch, sampled with exec_done.
REQ-014 Port: branch_offset  in  24  two's-complement word offset.
REQ-015 Port: jump  in  1  absolute jump, sampled with exec_done.
REQ-016 Port: jump_target  in  24  absolute jump address.
REQ-017 Port: halt  in  1  halt request, sampled with exec_done.
REQ-018 Port: stall  in  1  hold before starting the next fetch.
REQ-019 Port: halted  out  1  controller stopped.
REQ-020 Port: pc_wrap  out  1  one-cycle pulse when the new PC wraps modulo 2^24.

Function
REQ-021 States SHALL be IDLE, FETCH, WAIT_EXEC, UPDATE and HALT.
- IDLE: stall=0 -> FETCH; stall=1 -> stay.
- FETCH: fetch_req=1; fetch_ack=1 -> WAIT_EXEC; otherwise stay.
- WAIT_EXEC: exec_done=1 -> UPDATE, or HALT if halt=1; otherwise stay.
- UPDATE: stall=0 -> FETCH; stall=1 -> stay.
- HALT: absorbing; exited only by reset.
REQ-022 fetch_req SHALL be 1 only in FETCH; once asserted it SHALL NOT drop, and fetch_addr SHALL NOT change, until the cycle fetch_ack=1 is sampled.
REQ-023 On the FETCH edge with fetch_ack=1, instr SHALL load fetch_data and instr_valid SHALL be 1 for exactly the following cycle.
REQ-024 fetch_ack outside FETCH and exec_done outside WAIT_EXEC SHALL be ignored; stall SHALL be ignored outside IDLE and UPDATE.
REQ-025 On the WAIT_EXEC edge with exec_done=1, pc SHALL update with priority halt > jump > branch > sequential:
- halt or sequential: pc+INCREMENT.
- jump: jump_target.
- branch: pc+INCREMENT+branch_offset.
REQ-026 All PC arithmetic SHALL be modulo 2^24; the carry-out is discarded.
REQ-027 pc_wrap SHALL pulse on the update edge's following cycle when the exact (unbounded, signed) sum is below 0 or above 24'hFFFFFF; it SHALL be 0 for jump.
REQ-028 Latency: fetch_req SHALL rise 2 cycles after the exec_done cycle when stall=0; the minimum instruction period SHALL be 3 cycles.
REQ-029 halted SHALL be 1 in HALT, else 0; fetch_req SHALL be 0 in HALT.

Reset
REQ-030 Reset_n=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, pc=RESET_VECTOR;
- fetch_req=0, fetch_addr=RESET_VECTOR;
- instr=0, instr_valid=0, halted=0, pc_wrap=0.
REQ-031 Reset asserted mid-handshake SHALL abandon the fetch; the first fetch after release SHALL be to RESET_VECTOR.

Verification
REQ-032 Sequential: reset, ack every FETCH, exec_done 1 cycle later -> fetch_addr sequence 0,1,2,3, each instr_valid pulse once, 3-cycle period.
REQ-033 Branch/jump: pc=24'h000010, branch_taken=1, offset=24'hFFFFFC -> next fetch 24'h00000D; jump=1 and branch_taken=1 with target 24'h123456 -> next fetch 24'h123456.
REQ-034 Wrap: RESET_VECTOR=24'hFFFFFF, sequential -> next pc 24'h000000, pc_wrap one pulse; jump to 24'h000000 -> pc_wrap=0.
REQ-035 Handshake/stall: ack delayed 5 cycles -> fetch_req and fetch_addr stable all 5 cycles; stall=1 in UPDATE for 4 cycles -> fetch_req rises the cycle after stall falls.
REQ-036 Halt/reset: halt=1 with exec_done at pc=5 -> pc=6, halted=1, no further fetch_req; Reset_n pulse low mid-FETCH -> fetch_req=0 asynchronously, restart at RESET_VECTOR.
